// File: rtl/uart_rx_cfg_driver.sv
// UART receiver with configurable bit time, data width, parity and stop bits.
// rxd is synchronized, each bit is majority-voted around its centre, and data plus error flags are reported.
module uart_rx_cfg_driver #(
  parameter int CYCLES_PER_BIT = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] out,
  output logic                 outclk,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 busy
);

  generate
    if (CYCLES_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx_cfg_driver: CYCLES_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_cfg_driver: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_cfg_driver: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
      $error("uart_rx_cfg_driver: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int CW  = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int MID = CYCLES_PER_BIT / 2;
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] C_M0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_M1   = CW'(MID);
  localparam logic [CW-1:0] C_M2   = CW'(MID + 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic                 s1, s2, s3;
  logic [1:0]           warm;
  logic [CW-1:0]        cnt;
  logic [3:0]           bidx;
  logic                 m0, m1;
  logic [DATA_BITS-1:0] shreg;
  logic                 pacc, allz, ferr;
  logic                 bit_v, wrap, smp, start_det, abort, finish;

  // warm keeps a line that is already low at reset release from looking like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      warm <= 2'd0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign bit_v     = (m0 & m1) | (m0 & s2) | (m1 & s2);
  assign wrap      = (cnt == C_LAST);
  assign smp       = (state != IDLE) && (cnt == C_M2);
  assign start_det = (state == IDLE) && (warm == 2'd3) && !s2 && s3;
  assign abort     = smp && (state == START) && bit_v;
  assign finish    = smp && (state == STOP) && (bidx == S_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // the frame ends right after the last stop sample so the next start edge can land in the tail
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_det) state_n = START;
      START: if (abort) state_n = IDLE; else if (wrap) state_n = DATA;
      DATA:  if (wrap && bidx == D_LAST) state_n = (PARITY != 0) ? PAR : STOP;
      PAR:   if (wrap) state_n = STOP;
      STOP:  if (finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bidx       <= '0;
      m0         <= 1'b1;
      m1         <= 1'b1;
      shreg      <= '0;
      pacc       <= 1'b0;
      allz       <= 1'b0;
      ferr       <= 1'b0;
      out        <= '0;
      outclk     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      outclk <= finish;
      busy   <= (state_n != IDLE) | finish | abort;
      if (state == IDLE || state_n == IDLE || wrap) cnt <= '0;
      else                                          cnt <= cnt + CW'(1);
      if (state != state_n) bidx <= '0;
      else if (wrap)        bidx <= bidx + 4'd1;
      if (cnt == C_M0) m0 <= s2;
      if (cnt == C_M1) m1 <= s2;
      if (smp) begin
        case (state)
          START: begin
            pacc <= 1'b0;
            allz <= 1'b1;
            ferr <= 1'b0;
          end
          DATA: begin
            shreg <= {bit_v, shreg[DATA_BITS-1:1]};
            pacc  <= pacc ^ bit_v;
            if (bit_v) allz <= 1'b0;
          end
          PAR: begin
            pacc <= pacc ^ bit_v;
            if (bit_v) allz <= 1'b0;
          end
          STOP: begin
            if (!bit_v) ferr <= 1'b1;
            if (bit_v)  allz <= 1'b0;
            if (finish) begin
              out        <= shreg;
              parity_err <= (PARITY == 1) ? pacc : (PARITY == 2) ? ~pacc : 1'b0;
              frame_err  <= ferr | ~bit_v;
              brk        <= allz & ~bit_v;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg_driver.sv
// Bench for uart_rx_cfg_driver: three differently configured receivers driven with directed and random frames.
// Expected data, flags and outclk timing come from a frame-level model of the line protocol.
`timescale 1ns/1ps
module tb_uart_rx_cfg_driver;
  typedef struct { int cyc; logic [8:0] d; logic pe; logic fe; logic bk; } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rxd = 3'b111;
  wire  [7:0] out0, out1;
  wire  [5:0] out2;
  wire  [2:0] oc, pe, fe, bk, bz;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        q0[$], q1[$], q2[$];
  ev_t        last_exp[3];
  int         cpb_of[3] = '{10, 10, 7};
  int         db_of[3]  = '{8, 8, 6};
  int         par_of[3] = '{0, 1, 2};
  int         sb_of[3]  = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_driver u0 (
    .clk(clk), .rst(rst), .rxd(rxd[0]), .out(out0), .outclk(oc[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .brk(bk[0]), .busy(bz[0]));
  uart_rx_cfg_driver #(.CYCLES_PER_BIT(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd[1]), .out(out1), .outclk(oc[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .brk(bk[1]), .busy(bz[1]));
  uart_rx_cfg_driver #(.CYCLES_PER_BIT(7), .DATA_BITS(6), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rxd(rxd[2]), .out(out2), .outclk(oc[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .brk(bk[2]), .busy(bz[2]));

  always @(negedge clk) begin
    if (oc[0]) q0.push_back('{cyc, {1'b0, out0}, pe[0], fe[0], bk[0]});
    if (oc[1]) q1.push_back('{cyc, {1'b0, out1}, pe[1], fe[1], bk[1]});
    if (oc[2]) q2.push_back('{cyc, {3'b000, out2}, pe[2], fe[2], bk[2]});
  end

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ev_t qget(input int id, input int i);
    case (id)
      0: return q0[i];
      1: return q1[i];
      default: return q2[i];
    endcase
  endfunction

  task automatic clear_q;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  function automatic int nbits(input int id);
    return 1 + db_of[id] + ((par_of[id] != 0) ? 1 : 0) + sb_of[id];
  endfunction

  // Line driven at cycle k is seen by the edge detector at D = k + 2; outclk follows at
  // D + 1 + (N-1)*CPB + CPB/2 + 2.
  function automatic ev_t model(input int id, input int k, input logic [8:0] d, input logic pb,
                                input logic [1:0] stp);
    ev_t  e;
    logic x, allz;
    e.cyc = k + 5 + (nbits(id) - 1) * cpb_of[id] + cpb_of[id] / 2;
    e.d = '0;
    for (int i = 0; i < db_of[id]; i++) e.d[i] = d[i];
    x = (^e.d) ^ pb;
    e.pe = (par_of[id] == 0) ? 1'b0 : (par_of[id] == 1) ? x : ~x;
    e.fe = 1'b0;
    allz = (e.d == 9'd0) && (par_of[id] == 0 || pb == 1'b0);
    for (int s = 0; s < sb_of[id]; s++) begin
      if (!stp[s]) e.fe = 1'b1;
      else         allz = 1'b0;
    end
    e.bk = allz;
    return e;
  endfunction

  task automatic idle_cyc(input int n);
    rxd = 3'b111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int id, input logic [8:0] d, input logic pb, input logic [1:0] stp,
                            output int k);
    logic [15:0] bits;
    int          n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < db_of[id]; i++) begin bits[n] = d[i]; n++; end
    if (par_of[id] != 0) begin bits[n] = pb; n++; end
    for (int s = 0; s < sb_of[id]; s++) begin bits[n] = stp[s]; n++; end
    k = cyc;
    for (int i = 0; i < n; i++) begin
      rxd[id] = bits[i];
      repeat (cpb_of[id]) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total++; if (out0 !== 8'h00) begin bad++; $display("FAIL reset_out0 got=%0h want=0", out0); end
    total++; if (out1 !== 8'h00) begin bad++; $display("FAIL reset_out1 got=%0h want=0", out1); end
    total++; if (out2 !== 6'h00) begin bad++; $display("FAIL reset_out2 got=%0h want=0", out2); end
    total++; if (oc !== 3'b000) begin bad++; $display("FAIL reset_outclk got=%b want=000", oc); end
    total++; if (pe !== 3'b000) begin bad++; $display("FAIL reset_parity_err got=%b want=000", pe); end
    total++; if (fe !== 3'b000) begin bad++; $display("FAIL reset_frame_err got=%b want=000", fe); end
    total++; if (bk !== 3'b000) begin bad++; $display("FAIL reset_brk got=%b want=000", bk); end
    total++; if (bz !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", bz); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cyc(20);
  endtask

  task automatic test_a5;
    ev_t e, ev;
    int  k;
    clear_q;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, k);
    e = model(0, k, 9'h0A5, 1'b0, 2'b11);
    idle_cyc(20);
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL a5_count got=%0d want=1", qsize(0)); end
    if (qsize(0) >= 1) begin
      ev = qget(0, 0);
      total++; if (ev.cyc !== e.cyc) begin bad++; $display("FAIL a5_time got=%0d want=%0d", ev.cyc, e.cyc); end
      total++; if (ev.d !== e.d) begin bad++; $display("FAIL a5_data got=%0h want=%0h", ev.d, e.d); end
      total++; if ({ev.pe, ev.fe, ev.bk} !== 3'b000) begin
        bad++; $display("FAIL a5_flags got=%b want=000", {ev.pe, ev.fe, ev.bk}); end
    end
    last_exp[0] = e;
  endtask

  task automatic test_parity;
    ev_t e, ev;
    int  k;
    for (int c = 0; c < 2; c++) begin
      clear_q;
      send_frame(1, 9'h007, c[0], 2'b11, k);
      e = model(1, k, 9'h007, c[0], 2'b11);
      idle_cyc(20);
      total++; if (qsize(1) != 1) begin bad++; $display("FAIL par%0d_count got=%0d want=1", c, qsize(1)); end
      if (qsize(1) >= 1) begin
        ev = qget(1, 0);
        total++; if (ev.cyc !== e.cyc) begin bad++; $display("FAIL par%0d_time got=%0d want=%0d", c, ev.cyc, e.cyc); end
        total++; if (ev.d !== e.d) begin bad++; $display("FAIL par%0d_data got=%0h want=%0h", c, ev.d, e.d); end
        total++; if (ev.pe !== e.pe) begin bad++; $display("FAIL par%0d_perr got=%b want=%b", c, ev.pe, e.pe); end
        total++; if (ev.fe !== e.fe) begin bad++; $display("FAIL par%0d_ferr got=%b want=%b", c, ev.fe, e.fe); end
      end
      last_exp[1] = e;
    end
  endtask

  task automatic test_random;
    ev_t        e, ev;
    int         k;
    logic [8:0] d;
    logic       pb;
    logic [1:0] stp;
    for (int id = 0; id < 3; id++) begin
      for (int it = 0; it < 6; it++) begin
        d   = 9'($urandom);
        pb  = 1'($urandom_range(0, 1));
        stp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        if (it == 5) begin d = '0; pb = 1'b0; stp = 2'b00; end
        clear_q;
        send_frame(id, d, pb, stp, k);
        e = model(id, k, d, pb, stp);
        idle_cyc(2 * cpb_of[id] + 5);
        total++; if (qsize(id) != 1) begin bad++; $display("FAIL rnd%0d_%0d_count got=%0d want=1", id, it, qsize(id)); end
        if (qsize(id) >= 1) begin
          ev = qget(id, 0);
          total++; if (ev.cyc !== e.cyc) begin bad++; $display("FAIL rnd%0d_%0d_time got=%0d want=%0d", id, it, ev.cyc, e.cyc); end
          total++; if (ev.d !== e.d) begin bad++; $display("FAIL rnd%0d_%0d_data got=%0h want=%0h", id, it, ev.d, e.d); end
          total++; if ({ev.pe, ev.fe, ev.bk} !== {e.pe, e.fe, e.bk}) begin
            bad++; $display("FAIL rnd%0d_%0d_flags got=%b want=%b", id, it, {ev.pe, ev.fe, ev.bk}, {e.pe, e.fe, e.bk}); end
        end
        last_exp[id] = e;
      end
    end
  endtask

  task automatic test_glitch;
    int hi, fell;
    clear_q;
    hi = 0; fell = 0;
    rxd[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd[0] = 1'b1;
    for (int i = 0; i < 40 && fell == 0; i++) begin
      @(negedge clk);
      if (bz[0]) hi++;
      else if (hi > 0) fell = 1;
    end
    @(posedge clk); #1;
    total++; if (fell != 1) begin bad++; $display("FAIL glitch_busy_drop got=%0d want=1", fell); end
    total++; if (hi != 1 + cpb_of[0] / 2 + 2) begin
      bad++; $display("FAIL glitch_busy_len got=%0d want=%0d", hi, 1 + cpb_of[0] / 2 + 2); end
    idle_cyc(20);
    total++; if (qsize(0) != 0) begin bad++; $display("FAIL glitch_outclk got=%0d want=0", qsize(0)); end
    total++; if ({1'b0, out0} !== last_exp[0].d) begin bad++; $display("FAIL glitch_out got=%0h want=%0h", out0, last_exp[0].d); end
    total++; if ({pe[0], fe[0], bk[0]} !== {last_exp[0].pe, last_exp[0].fe, last_exp[0].bk}) begin
      bad++; $display("FAIL glitch_flags got=%b want=%b", {pe[0], fe[0], bk[0]},
                      {last_exp[0].pe, last_exp[0].fe, last_exp[0].bk}); end
  endtask

  task automatic test_break;
    ev_t e, ev;
    int  k;
    clear_q;
    k = cyc;
    e = model(0, k, 9'h000, 1'b0, 2'b00);
    rxd[0] = 1'b0;
    repeat (12 * cpb_of[0]) @(posedge clk);
    #1;
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL brk_count_low got=%0d want=1", qsize(0)); end
    if (qsize(0) >= 1) begin
      ev = qget(0, 0);
      total++; if (ev.cyc !== e.cyc) begin bad++; $display("FAIL brk_time got=%0d want=%0d", ev.cyc, e.cyc); end
      total++; if (ev.d !== 9'h000) begin bad++; $display("FAIL brk_data got=%0h want=0", ev.d); end
      total++; if ({ev.pe, ev.fe, ev.bk} !== 3'b011) begin
        bad++; $display("FAIL brk_flags got=%b want=011", {ev.pe, ev.fe, ev.bk}); end
    end
    idle_cyc(30);
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL brk_count_high got=%0d want=1", qsize(0)); end
    clear_q;
    send_frame(0, 9'h055, 1'b0, 2'b11, k);
    e = model(0, k, 9'h055, 1'b0, 2'b11);
    idle_cyc(20);
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL brk55_count got=%0d want=1", qsize(0)); end
    if (qsize(0) >= 1) begin
      ev = qget(0, 0);
      total++; if (ev.d !== e.d) begin bad++; $display("FAIL brk55_data got=%0h want=%0h", ev.d, e.d); end
      total++; if ({ev.fe, ev.bk} !== 2'b00) begin bad++; $display("FAIL brk55_flags got=%b want=00", {ev.fe, ev.bk}); end
    end
    last_exp[0] = e;
  endtask

  task automatic test_back_to_back;
    ev_t e1, e2, a, b;
    int  k1, k2;
    clear_q;
    send_frame(0, 9'h000, 1'b0, 2'b11, k1);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, k2);
    e1 = model(0, k1, 9'h000, 1'b0, 2'b11);
    e2 = model(0, k2, 9'h0FF, 1'b0, 2'b11);
    idle_cyc(25);
    total++; if (qsize(0) != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", qsize(0)); end
    if (qsize(0) >= 2) begin
      a = qget(0, 0);
      b = qget(0, 1);
      total++; if (b.cyc - a.cyc != 100) begin bad++; $display("FAIL b2b_gap got=%0d want=100", b.cyc - a.cyc); end
      total++; if (a.cyc !== e1.cyc) begin bad++; $display("FAIL b2b_time1 got=%0d want=%0d", a.cyc, e1.cyc); end
      total++; if (a.d !== e1.d) begin bad++; $display("FAIL b2b_data1 got=%0h want=%0h", a.d, e1.d); end
      total++; if (b.d !== e2.d) begin bad++; $display("FAIL b2b_data2 got=%0h want=%0h", b.d, e2.d); end
      total++; if ({a.pe, a.fe, a.bk, b.pe, b.fe, b.bk} !== 6'b0) begin
        bad++; $display("FAIL b2b_flags got=%b want=000000", {a.pe, a.fe, a.bk, b.pe, b.fe, b.bk}); end
    end
    last_exp[0] = e2;
  endtask

  task automatic test_reset_mid;
    ev_t        e, ev;
    int         k;
    logic [7:0] d;
    clear_q;
    d = 8'h5A;
    rxd[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rxd[0] = d[i];
      repeat (10) @(posedge clk);
      #1;
    end
    rxd[0] = d[4];
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (out0 !== 8'h00) begin bad++; $display("FAIL rstmid_out0 got=%0h want=0", out0); end
    total++; if (out1 !== 8'h00) begin bad++; $display("FAIL rstmid_out1 got=%0h want=0", out1); end
    total++; if (out2 !== 6'h00) begin bad++; $display("FAIL rstmid_out2 got=%0h want=0", out2); end
    total++; if (bz !== 3'b000) begin bad++; $display("FAIL rstmid_busy got=%b want=000", bz); end
    total++; if ({oc, pe, fe, bk} !== 12'h000) begin
      bad++; $display("FAIL rstmid_flags got=%0h want=0", {oc, pe, fe, bk}); end
    @(posedge clk); #1 rxd = 3'b111;
    @(posedge clk); #1 rst = 1'b0;
    idle_cyc(40);
    total++; if (qsize(0) != 0) begin bad++; $display("FAIL rstmid_aborted got=%0d want=0", qsize(0)); end
    send_frame(0, 9'h03C, 1'b0, 2'b11, k);
    e = model(0, k, 9'h03C, 1'b0, 2'b11);
    idle_cyc(20);
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", qsize(0)); end
    if (qsize(0) >= 1) begin
      ev = qget(0, 0);
      total++; if (ev.d !== e.d) begin bad++; $display("FAIL rstmid_data got=%0h want=%0h", ev.d, e.d); end
      total++; if (ev.cyc !== e.cyc) begin bad++; $display("FAIL rstmid_time got=%0d want=%0d", ev.cyc, e.cyc); end
    end
  endtask

  task automatic test_low_at_release;
    ev_t e, ev;
    int  hi, k;
    clear_q;
    hi = 0;
    rxd[0] = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bz[0]) hi++;
    end
    @(posedge clk); #1;
    total++; if (hi != 0) begin bad++; $display("FAIL lowrel_busy got=%0d want=0", hi); end
    total++; if (qsize(0) != 0) begin bad++; $display("FAIL lowrel_outclk got=%0d want=0", qsize(0)); end
    idle_cyc(30);
    send_frame(0, 9'h081, 1'b0, 2'b11, k);
    e = model(0, k, 9'h081, 1'b0, 2'b11);
    idle_cyc(20);
    total++; if (qsize(0) != 1) begin bad++; $display("FAIL lowrel_count got=%0d want=1", qsize(0)); end
    if (qsize(0) >= 1) begin
      ev = qget(0, 0);
      total++; if (ev.d !== e.d) begin bad++; $display("FAIL lowrel_data got=%0h want=%0h", ev.d, e.d); end
    end
  endtask

  initial begin
    test_reset;
    test_a5;
    test_parity;
    test_random;
    test_glitch;
    test_break;
    test_back_to_back;
    test_reset_mid;
    test_low_at_release;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_cfg_driver.md
UART_RX_CFG_DRIVER -- requirements
Module: uart_rx_cfg_driver

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 10: clk cycles per bit; legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 rxd  input  1  asynchronous serial line; idles high.
REQ-008 out  output  DATA_BITS  received data, LSB first on the line.
REQ-009 outclk  output  1  one-cycle pulse; out and flags valid.
REQ-010 parity_err  output  1  parity mismatch on the last frame.
REQ-011 frame_err  output  1  a stop bit sampled low on the last frame.
REQ-012 brk  output  1  break detected on the last frame.
REQ-013 busy  output  1  frame reception in progress.

Function
REQ-014 Illegal parameter values SHALL fail elaboration.
REQ-015 rxd SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; all three reset to 1.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-017 Start detection: in IDLE, a cycle D with s2 == 0 and s3 == 1 SHALL move to START with bit counter cnt = 0 at D+1.
REQ-018 Bit timing: for N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS, bit b (b = 0..N-1) SHALL occupy cycles D+1+b*CYCLES_PER_BIT .. D+(b+1)*CYCLES_PER_BIT; cnt SHALL count 0..CYCLES_PER_BIT-1 and wrap.
REQ-019 Sampling: with MID = CYCLES_PER_BIT/2 (floor), each bit value SHALL be the 2-of-3 majority of s2 at cnt = MID-1, MID and MID+1.
REQ-020 False start: a START majority of 1 SHALL return the FSM to IDLE at cnt = MID+2, with no outclk and no flag update.
REQ-021 DATA SHALL shift DATA_BITS samples LSB-first, then go to PAR if PARITY != 0, else to STOP.
REQ-022 In PAR, parity_err SHALL be computed as follows: even mode, XOR of data and parity bit != 0; odd mode, that XOR != 1; PARITY = 0 forces parity_err = 0.
REQ-023 STOP SHALL sample STOP_BITS bits; any stop bit with a majority of 0 SHALL set frame_err.
REQ-024 outclk SHALL be high only in cycle D+1+(N-1)*CYCLES_PER_BIT+MID+2.
REQ-025 In that same cycle the FSM SHALL return to IDLE, so a start edge in the remaining half stop bit is accepted (back-to-back frames, baud drift tolerance).
REQ-026 out, parity_err, frame_err and brk SHALL update only in the outclk cycle and hold until the next outclk.
REQ-027 brk SHALL be set when all data bits, the parity bit (if present) and all stop bits sample 0; frame_err SHALL also be 1.
REQ-028 After a break, no new start SHALL be accepted until s2 has been 1 for at least one cycle (inherent in REQ-017).
REQ-029 busy SHALL be high from D+1 through the outclk cycle or the false-start abort cycle inclusive, and low otherwise.
REQ-030 rxd transitions in the cycle of sampling SHALL be resolved solely by the synchronizer; no other metastability handling.

Reset
REQ-031 On rst assertion, immediately and without clk: FSM to IDLE, cnt 0, out 0, outclk 0, parity_err 0, frame_err 0, brk 0, busy 0, s1/s2/s3 to 1.
REQ-032 Reset mid-frame SHALL discard the partial frame with no outclk.
REQ-033 After release, a line already low SHALL NOT start a frame until a high-to-low edge is seen.

Verification
REQ-034 Defaults, frame 0xA5 driven at 10 cycles/bit -> exactly one outclk at D+98; out = 0xA5; parity_err, frame_err and brk all 0.
REQ-035 PARITY = 1, data 0x07 with parity bit 0 -> outclk; out = 0x07; parity_err = 1; frame_err = 0.
REQ-036 Idle line with a 3-cycle low glitch -> no outclk; busy high, then low by cnt = MID+2; no flags change.
REQ-037 rxd low for 12 bit times, then high -> one outclk; out = 0x00; brk = 1; frame_err = 1; no further outclk until rxd returns high and a fresh 0x55 frame arrives, which then reads 0x55 with brk = 0.
REQ-038 Back-to-back frames 0x00 then 0xFF with no idle gap -> two outclks exactly 100 cycles apart; values correct; no errors.
REQ-039 rst pulsed during data bit 4, then frame 0x3C sent after release -> outputs 0 immediately; no outclk for the aborted frame; next outclk carries out = 0x3C.
